// File: rtl/maria_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maria_arb_pkg
// Description : Shared types and default constants for the Maria bus arbiter:
//               arbiter state encoding, DMA owner encoding and a small helper
//               for the owner hand-over in RELEASE.
// Revision    : 1.0 - initial release
// ============================================================================
package maria_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HALT    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Which DMA engine currently owns (or is about to own) the bus
    typedef enum logic {
        OWN_ZP = 1'b0,
        OWN_DP = 1'b1
    } owner_t;

    // Default timing constants
    localparam int unsigned C_HALT_SETUP = 2;    // pclk_2 falls before first grant
    localparam int unsigned C_TURNAROUND = 1;    // dead cycles between owners
    localparam int unsigned C_MAX_GRANT  = 512;  // grant length that raises a kill
    localparam int unsigned C_CNT_W      = 10;   // grant counter width

    // The requester that is not the current owner
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_ZP) ? OWN_DP : OWN_ZP;
    endfunction

endpackage : maria_arb_pkg
`default_nettype wire

// File: rtl/phi2_edge_counter.sv
`default_nettype none
// ============================================================================
// Module      : phi2_edge_counter
// Description : Detects falling edges of the CPU phase-2 clock (already in the
//               sysclk domain) against a registered copy, and counts down
//               HALT_SETUP of them. 'done' is a combinational strobe on the
//               sysclk edge that sees the final falling edge, so the arbiter
//               can grant on that very edge.
// Revision    : 1.0 - initial release
// ============================================================================
module phi2_edge_counter #(
    parameter int unsigned HALT_SETUP = 2
) (
    input  logic sysclk,
    input  logic reset_b,
    input  logic pclk_2,
    input  logic clear,
    output logic done
);

    // Enough bits to hold HALT_SETUP itself (minimum one bit)
    localparam int unsigned CW = (HALT_SETUP < 2) ? 1 : $clog2(HALT_SETUP + 1);
    localparam logic [CW-1:0] LOAD = CW'(HALT_SETUP);

    logic          pclk_q;
    logic          pclk_d;
    logic [CW-1:0] remain_q;
    logic [CW-1:0] remain_d;
    logic          fall;

    // Edge detect and countdown; held at full count while cleared
    always_comb begin
        pclk_d   = pclk_2;
        fall     = pclk_q & ~pclk_2;
        done     = ~clear & fall & (remain_q == CW'(1));
        remain_d = remain_q;
        if (clear) begin
            remain_d = LOAD;
        end else if (fall && (remain_q != '0)) begin
            remain_d = remain_q - CW'(1);
        end
    end

    // Previous phase-2 sample and remaining-edge count
    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            pclk_q   <= 1'b0;
            remain_q <= LOAD;
        end else begin
            pclk_q   <= pclk_d;
            remain_q <= remain_d;
        end
    end

endmodule : phi2_edge_counter
`default_nettype wire

// File: rtl/maria_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : maria_bus_arbiter
// Description : Owns the shared address bus between the 6502 and the Maria
//               DMA engine. Halts the CPU, waits HALT_SETUP phase-2 falling
//               edges, grants the bus to one DMA owner (ZP wins ties), then
//               returns it after a TURNAROUND gap, handing directly to the
//               other requester when one is waiting. Single source of halt_b
//               and drive_AB. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module maria_bus_arbiter
    import maria_arb_pkg::*;
#(
    parameter int unsigned HALT_SETUP = C_HALT_SETUP,
    parameter int unsigned TURNAROUND = C_TURNAROUND,  // must be >= 1
    parameter int unsigned MAX_GRANT  = C_MAX_GRANT,
    parameter int unsigned CNT_W      = C_CNT_W
) (
    input  logic             sysclk,
    input  logic             reset_b,
    input  logic             enable,
    input  logic             pclk_2,
    input  logic             zp_req,
    input  logic             dp_req,
    input  logic             zp_done,
    input  logic             dp_done,
    output logic             halt_b,
    output logic             drive_AB,
    output logic             zp_grant,
    output logic             dp_grant,
    output logic             dma_kill,
    output logic [CNT_W-1:0] grant_len
);

    // Turnaround counter holds TURNAROUND-1 down to 0 (minimum one bit)
    localparam int unsigned    TW      = (TURNAROUND < 3) ? 1 : $clog2(TURNAROUND);
    localparam logic [TW-1:0]  TURN_LD = TW'(TURNAROUND - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] KILL_AT = CNT_W'(MAX_GRANT - 1);

    arb_state_t       state_q,     state_d;
    owner_t           owner_q,     owner_d;
    logic             halt_b_q,    halt_b_d;
    logic             drive_ab_q,  drive_ab_d;
    logic             zp_grant_q,  zp_grant_d;
    logic             dp_grant_q,  dp_grant_d;
    logic             dma_kill_q,  dma_kill_d;
    logic             killed_q,    killed_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] grant_len_q, grant_len_d;
    logic [TW-1:0]    turn_q,      turn_d;

    logic             setup_done;
    logic             owner_req;
    logic             owner_done;
    logic             other_req;
    logic [CNT_W-1:0] cnt_inc;

    // Phase-2 falling-edge countdown, armed only while in HALT
    phi2_edge_counter #(
        .HALT_SETUP (HALT_SETUP)
    ) u_phi2_edge_counter (
        .sysclk  (sysclk),
        .reset_b (reset_b),
        .pclk_2  (pclk_2),
        .clear   (state_q != HALT),
        .done    (setup_done)
    );

    // Request/done routing relative to the current owner, and saturating count
    always_comb begin
        owner_req  = (owner_q == OWN_ZP) ? zp_req  : dp_req;
        owner_done = (owner_q == OWN_ZP) ? zp_done : dp_done;
        other_req  = (owner_q == OWN_ZP) ? dp_req  : zp_req;
        cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
    end

    // Next-state and next-output logic for the arbiter sequence
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        halt_b_d    = halt_b_q;
        drive_ab_d  = drive_ab_q;
        zp_grant_d  = zp_grant_q;
        dp_grant_d  = dp_grant_q;
        dma_kill_d  = 1'b0;
        killed_d    = killed_q;
        cnt_d       = cnt_q;
        grant_len_d = grant_len_q;
        turn_d      = turn_q;

        case (state_q)
            IDLE: begin
                halt_b_d   = 1'b1;
                drive_ab_d = 1'b0;
                zp_grant_d = 1'b0;
                dp_grant_d = 1'b0;
                if (enable && (zp_req || dp_req)) begin
                    owner_d  = zp_req ? OWN_ZP : OWN_DP;
                    halt_b_d = 1'b0;
                    state_d  = HALT;
                end
            end

            HALT: begin
                // A withdrawn request aborts before any grant is issued
                if (!owner_req) begin
                    halt_b_d = 1'b1;
                    state_d  = IDLE;
                end else if (setup_done) begin
                    drive_ab_d = 1'b1;
                    zp_grant_d = (owner_q == OWN_ZP);
                    dp_grant_d = (owner_q == OWN_DP);
                    cnt_d      = '0;
                    killed_d   = 1'b0;
                    state_d    = GRANT;
                end
            end

            GRANT: begin
                // Losing enable ends the grant exactly like a done pulse
                if (owner_done || !enable) begin
                    drive_ab_d  = 1'b0;
                    zp_grant_d  = 1'b0;
                    dp_grant_d  = 1'b0;
                    grant_len_d = cnt_inc;
                    turn_d      = TURN_LD;
                    state_d     = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                    if ((cnt_inc == KILL_AT) && !killed_q) begin
                        dma_kill_d = 1'b1;
                        killed_d   = 1'b1;
                    end
                end
            end

            RELEASE: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - TW'(1);
                end else if (enable && other_req) begin
                    // Direct hand-over: CPU is already halted, skip setup wait
                    owner_d    = other_owner(owner_q);
                    drive_ab_d = 1'b1;
                    zp_grant_d = (owner_q == OWN_DP);
                    dp_grant_d = (owner_q == OWN_ZP);
                    cnt_d      = '0;
                    killed_d   = 1'b0;
                    state_d    = GRANT;
                end else begin
                    halt_b_d = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                halt_b_d   = 1'b1;
                drive_ab_d = 1'b0;
                zp_grant_d = 1'b0;
                dp_grant_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus immediately
    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            owner_q     <= OWN_ZP;
            halt_b_q    <= 1'b1;
            drive_ab_q  <= 1'b0;
            zp_grant_q  <= 1'b0;
            dp_grant_q  <= 1'b0;
            dma_kill_q  <= 1'b0;
            killed_q    <= 1'b0;
            cnt_q       <= '0;
            grant_len_q <= '0;
            turn_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            halt_b_q    <= halt_b_d;
            drive_ab_q  <= drive_ab_d;
            zp_grant_q  <= zp_grant_d;
            dp_grant_q  <= dp_grant_d;
            dma_kill_q  <= dma_kill_d;
            killed_q    <= killed_d;
            cnt_q       <= cnt_d;
            grant_len_q <= grant_len_d;
            turn_q      <= turn_d;
        end
    end

    assign halt_b    = halt_b_q;
    assign drive_AB  = drive_ab_q;
    assign zp_grant  = zp_grant_q;
    assign dp_grant  = dp_grant_q;
    assign dma_kill  = dma_kill_q;
    assign grant_len = grant_len_q;

endmodule : maria_bus_arbiter
`default_nettype wire

// File: tb/tb_maria_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_maria_bus_arbiter
// Description : Self-checking bench for maria_bus_arbiter. Randomised phase-2
//               period, idle gaps and grant lengths; expected timings come
//               from the arbitration rules (halt one cycle after request,
//               grant on the HALT_SETUP-th observed phase-2 fall, drop one
//               cycle after done, one turnaround cycle, kill at cycle
//               MAX_GRANT-1, grant_len = cycles the grant was high).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maria_bus_arbiter;

    localparam int CNT_W     = 10;
    localparam int MAX_GRANT = 512;

    logic             sysclk  = 1'b0;
    logic             reset_b = 1'b1;
    logic             enable  = 1'b0;
    logic             pclk_2  = 1'b1;
    logic             zp_req  = 1'b0;
    logic             dp_req  = 1'b0;
    logic             zp_done = 1'b0;
    logic             dp_done = 1'b0;
    logic             halt_b;
    logic             drive_AB;
    logic             zp_grant;
    logic             dp_grant;
    logic             dma_kill;
    logic [CNT_W-1:0] grant_len;

    int   checks    = 0;
    int   failures  = 0;
    int   pclk_half = 3;
    int   ph_cnt    = 0;
    logic pclk_prev_s = 1'b1;
    logic fall_now    = 1'b0;

    maria_bus_arbiter dut (
        .sysclk    (sysclk),
        .reset_b   (reset_b),
        .enable    (enable),
        .pclk_2    (pclk_2),
        .zp_req    (zp_req),
        .dp_req    (dp_req),
        .zp_done   (zp_done),
        .dp_done   (dp_done),
        .halt_b    (halt_b),
        .drive_AB  (drive_AB),
        .zp_grant  (zp_grant),
        .dp_grant  (dp_grant),
        .dma_kill  (dma_kill),
        .grant_len (grant_len)
    );

    always #5 sysclk = ~sysclk;

    // Phase-2 clock: toggles every pclk_half sysclk cycles, just after the edge
    initial begin
        forever begin
            @(posedge sysclk);
            #2;
            ph_cnt++;
            if (ph_cnt >= pclk_half) begin
                ph_cnt = 0;
                pclk_2 = ~pclk_2;
            end
        end
    end

    // Bus invariants, sampled mid-cycle
    always @(negedge sysclk) begin
        checks++;
        if ((zp_grant && dp_grant) || (drive_AB !== (zp_grant | dp_grant)) ||
            ((zp_grant || dp_grant) && halt_b)) begin
            failures++;
            $display("FAIL invariant: zp_grant=%b dp_grant=%b drive_AB=%b halt_b=%b, required single grant, drive_AB=grant, halt_b=0 when granted",
                     zp_grant, dp_grant, drive_AB, halt_b);
        end
    end

    // Advance one sysclk cycle; note whether the DUT saw a phase-2 fall on it
    task automatic cyc();
        @(posedge sysclk);
        #1;
        fall_now    = pclk_prev_s && !pclk_2;
        pclk_prev_s = pclk_2;
    endtask

    // Advance until the next observed phase-2 fall (bounded)
    task automatic wait_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (fall_now) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if (halt_b !== 1'b1 || drive_AB !== 1'b0 || zp_grant !== 1'b0 ||
            dp_grant !== 1'b0 || dma_kill !== 1'b0 || grant_len !== '0) begin
            failures++;
            $display("FAIL reset_values: halt_b=%b drive_AB=%b zp=%b dp=%b kill=%b len=%0d, required 1 0 0 0 0 0",
                     halt_b, drive_AB, zp_grant, dp_grant, dma_kill, grant_len);
        end
        repeat (3) cyc();
        #2 reset_b = 1'b1;
        enable = 1'b1;
        cyc();
    endtask

    task automatic test_single_zp();
        for (int it = 0; it < 3; it++) begin
            int len;
            bit ok;
            pclk_half = $urandom_range(2, 5);
            len       = $urandom_range(3, 20);
            repeat ($urandom_range(1, 7)) cyc();
            zp_req = 1'b1;
            cyc();
            checks++;
            if (halt_b !== 1'b0 || drive_AB !== 1'b0) begin
                failures++;
                $display("FAIL single_halt_fall: halt_b=%b drive_AB=%b, required 0 0", halt_b, drive_AB);
            end
            wait_fall(ok);
            checks++;
            if (!ok || zp_grant !== 1'b0) begin
                failures++;
                $display("FAIL single_early_grant: fall_seen=%b zp_grant=%b, required 1 0", ok, zp_grant);
            end
            wait_fall(ok);
            checks++;
            if (!ok || zp_grant !== 1'b1 || drive_AB !== 1'b1 || dp_grant !== 1'b0) begin
                failures++;
                $display("FAIL single_grant: fall_seen=%b zp=%b drive=%b dp=%b, required 1 1 1 0",
                         ok, zp_grant, drive_AB, dp_grant);
            end
            for (int k = 1; k < len; k++) begin
                dp_done = (k == 2);   // non-owner done must be ignored
                cyc();
            end
            dp_done = 1'b0;
            checks++;
            if (zp_grant !== 1'b1) begin
                failures++;
                $display("FAIL single_hold: zp_grant=%b, required 1", zp_grant);
            end
            zp_done = 1'b1;
            zp_req  = 1'b0;
            cyc();
            zp_done = 1'b0;
            checks++;
            if (zp_grant !== 1'b0 || drive_AB !== 1'b0 || halt_b !== 1'b0 ||
                grant_len !== CNT_W'(len) || dma_kill !== 1'b0) begin
                failures++;
                $display("FAIL single_release: zp=%b drive=%b halt=%b len=%0d kill=%b, required 0 0 0 %0d 0",
                         zp_grant, drive_AB, halt_b, grant_len, dma_kill, len);
            end
            cyc();
            checks++;
            if (halt_b !== 1'b1) begin
                failures++;
                $display("FAIL single_resume: halt_b=%b, required 1", halt_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 2; it++) begin
            int len1;
            int len2;
            bit ok;
            bit ok2;
            pclk_half = $urandom_range(2, 5);
            len1      = $urandom_range(2, 15);
            len2      = $urandom_range(2, 15);
            repeat ($urandom_range(1, 5)) cyc();
            zp_req = 1'b1;
            dp_req = 1'b1;
            cyc();
            wait_fall(ok);
            wait_fall(ok2);
            checks++;
            if (!ok || !ok2 || zp_grant !== 1'b1 || dp_grant !== 1'b0) begin
                failures++;
                $display("FAIL b2b_zp_first: zp=%b dp=%b, required 1 0", zp_grant, dp_grant);
            end
            repeat (len1 - 1) cyc();
            zp_done = 1'b1;
            zp_req  = 1'b0;
            cyc();
            zp_done = 1'b0;
            checks++;
            if (zp_grant !== 1'b0 || dp_grant !== 1'b0 || drive_AB !== 1'b0 ||
                halt_b !== 1'b0 || grant_len !== CNT_W'(len1)) begin
                failures++;
                $display("FAIL b2b_gap: zp=%b dp=%b drive=%b halt=%b len=%0d, required 0 0 0 0 %0d",
                         zp_grant, dp_grant, drive_AB, halt_b, grant_len, len1);
            end
            cyc();
            checks++;
            if (dp_grant !== 1'b1 || drive_AB !== 1'b1 || halt_b !== 1'b0) begin
                failures++;
                $display("FAIL b2b_dp_handover: dp=%b drive=%b halt=%b, required 1 1 0",
                         dp_grant, drive_AB, halt_b);
            end
            repeat (len2 - 1) cyc();
            dp_done = 1'b1;
            dp_req  = 1'b0;
            cyc();
            dp_done = 1'b0;
            checks++;
            if (dp_grant !== 1'b0 || grant_len !== CNT_W'(len2)) begin
                failures++;
                $display("FAIL b2b_dp_release: dp=%b len=%0d, required 0 %0d", dp_grant, grant_len, len2);
            end
            cyc();
            checks++;
            if (halt_b !== 1'b1) begin
                failures++;
                $display("FAIL b2b_resume: halt_b=%b, required 1", halt_b);
            end
        end
    endtask

    task automatic test_kill();
        int  kills;
        int  kill_at;
        bit  ok;
        bit  ok2;
        kills   = 0;
        kill_at = -1;
        pclk_half = $urandom_range(2, 5);
        dp_req = 1'b1;
        cyc();
        wait_fall(ok);
        wait_fall(ok2);
        checks++;
        if (!ok || !ok2 || dp_grant !== 1'b1 || dma_kill !== 1'b0) begin
            failures++;
            $display("FAIL kill_grant: dp=%b kill=%b, required 1 0", dp_grant, dma_kill);
        end
        for (int k = 1; k < 600; k++) begin
            cyc();
            if (dma_kill === 1'b1) begin
                kills++;
                kill_at = k;
            end
        end
        checks++;
        if (kills != 1 || kill_at != MAX_GRANT - 1 || dp_grant !== 1'b1) begin
            failures++;
            $display("FAIL kill_pulse: pulses=%0d at_cycle=%0d dp=%b, required 1 %0d 1",
                     kills, kill_at, dp_grant, MAX_GRANT - 1);
        end
        dp_done = 1'b1;
        dp_req  = 1'b0;
        cyc();
        dp_done = 1'b0;
        checks++;
        if (grant_len !== CNT_W'(600) || dp_grant !== 1'b0) begin
            failures++;
            $display("FAIL kill_len: len=%0d dp=%b, required 600 0", grant_len, dp_grant);
        end
        cyc();
    endtask

    task automatic test_abort();
        bit ok;
        pclk_half = $urandom_range(3, 5);
        repeat ($urandom_range(1, 4)) cyc();
        dp_req = 1'b1;
        cyc();
        wait_fall(ok);
        checks++;
        if (!ok || dp_grant !== 1'b0 || halt_b !== 1'b0) begin
            failures++;
            $display("FAIL abort_pre: dp=%b halt=%b, required 0 0", dp_grant, halt_b);
        end
        dp_req = 1'b0;
        cyc();
        checks++;
        if (halt_b !== 1'b1 || dp_grant !== 1'b0) begin
            failures++;
            $display("FAIL abort_resume: halt=%b dp=%b, required 1 0", halt_b, dp_grant);
        end
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (dp_grant !== 1'b0 || halt_b !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL abort_stays_idle: dp=%b halt=%b, required 0 1", dp_grant, halt_b);
                break;
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        bit ok;
        bit ok2;
        pclk_half = $urandom_range(2, 5);
        zp_req = 1'b1;
        cyc();
        wait_fall(ok);
        wait_fall(ok2);
        repeat (3) cyc();
        checks++;
        if (!ok || !ok2 || zp_grant !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_grant: zp=%b, required 1", zp_grant);
        end
        #2 reset_b = 1'b0;
        #1;
        checks++;
        if (halt_b !== 1'b1 || drive_AB !== 1'b0 || zp_grant !== 1'b0 || dp_grant !== 1'b0) begin
            failures++;
            $display("FAIL rst_async_drop: halt=%b drive=%b zp=%b dp=%b, required 1 0 0 0",
                     halt_b, drive_AB, zp_grant, dp_grant);
        end
        reset_b = 1'b1;
        cyc();
        checks++;
        if (halt_b !== 1'b0 || zp_grant !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart_halt: halt=%b zp=%b, required 0 0", halt_b, zp_grant);
        end
        wait_fall(ok);
        wait_fall(ok2);
        checks++;
        if (!ok || !ok2 || zp_grant !== 1'b1 || drive_AB !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart_grant: zp=%b drive=%b, required 1 1", zp_grant, drive_AB);
        end
        zp_done = 1'b1;
        zp_req  = 1'b0;
        cyc();
        zp_done = 1'b0;
        checks++;
        if (grant_len !== CNT_W'(1) || zp_grant !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart_len: len=%0d zp=%b, required 1 0", grant_len, zp_grant);
        end
        cyc();
    endtask

    task automatic test_enable();
        bit ok;
        bit ok2;
        // Done pulses in IDLE are ignored
        zp_done = 1'b1;
        cyc();
        zp_done = 1'b0;
        enable  = 1'b0;
        zp_req  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (halt_b !== 1'b1 || zp_grant !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL enable_off_blocks: halt=%b zp=%b, required 1 0", halt_b, zp_grant);
                break;
            end
        end
        checks++;
        if (halt_b !== 1'b1) begin
            failures++;
            $display("FAIL enable_off_idle: halt=%b, required 1", halt_b);
        end
        enable = 1'b1;
        cyc();
        wait_fall(ok);
        wait_fall(ok2);
        repeat ($urandom_range(1, 6)) cyc();
        checks++;
        if (!ok || !ok2 || zp_grant !== 1'b1) begin
            failures++;
            $display("FAIL enable_grant: zp=%b, required 1", zp_grant);
        end
        enable = 1'b0;
        cyc();
        checks++;
        if (zp_grant !== 1'b0 || drive_AB !== 1'b0 || halt_b !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop_release: zp=%b drive=%b halt=%b, required 0 0 0",
                     zp_grant, drive_AB, halt_b);
        end
        cyc();
        repeat (3) cyc();
        checks++;
        if (halt_b !== 1'b1 || zp_grant !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop_idle: halt=%b zp=%b, required 1 0", halt_b, zp_grant);
        end
        zp_req = 1'b0;
        enable = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_zp();
        test_back_to_back();
        test_kill();
        test_abort();
        test_reset_mid_grant();
        test_enable();
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_maria_bus_arbiter
`default_nettype wire
